fetch_unit: RTL and testbench

//  Instruction-fetch initiator for the word-indexed, combinational-read instruction ROM.
//  - Owns the PC and drives the ROM address.
//  - Captures the returned word into an output register, with PC tag.
//  - Hands instructions to decode over a valid/ready handshake.
//  - Supports start, branch redirect, and halt at the end of the program image.

---
 rtl/fetch_unit.sv | 215 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch initiator for a word-indexed instruction ROM with
//   combinational read. It owns the program counter and drives the ROM
//   address. Each returned word is captured into an output register together
//   with the PC it came from. The output register is handed to decode over a
//   valid/ready handshake. The unit can be started, redirected by a taken
//   branch or jump, and it halts after fetching the last word of the image.
//
// Parameters
//   N    data / address width (the ROM address is a word index)
//   INS  number of instructions in the ROM image; legal PCs are 0..INS-1
//
// Ports
//   clk            in   1  clock, rising edge
//   rst            in   1  asynchronous active-high reset
//   start_i        in   1  begin fetching from PC 0 (honoured in IDLE only)
//   imem_pc_o      out  N  ROM word address (the PC register)
//   imem_instr_i   in   N  ROM read data for imem_pc_o, same cycle
//   instr_o        out  N  fetched instruction
//   instr_pc_o     out  N  PC of instr_o
//   valid_o        out  1  instr_o / instr_pc_o hold a word for decode
//   ready_i        in   1  decode accepts; transfer on valid_o && ready_i
//   redirect_i     in   1  taken branch / jump, overrides sequential fetch
//   redirect_pc_i  in   N  redirect target (word index)
//   done_o         out  1  halted and output register empty
//   err_o          out  1  sticky: a redirect targeted a PC >= INS
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int N   = 32,
    parameter int INS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    output logic [N-1:0] imem_pc_o,
    input  logic [N-1:0] imem_instr_i,
    output logic [N-1:0] instr_o,
    output logic [N-1:0] instr_pc_o,
    output logic         valid_o,
    input  logic         ready_i,
    input  logic         redirect_i,
    input  logic [N-1:0] redirect_pc_i,
    output logic         done_o,
    output logic         err_o
);

    localparam logic [N-1:0] ZERO_PC = {N{1'b0}};
    localparam logic [N-1:0] ONE_PC  = N'(1);
    localparam logic [N-1:0] INS_N   = N'(INS);
    localparam logic [N-1:0] LAST_PC = N'(INS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t       state_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] instr_q;
    logic [N-1:0] instr_pc_q;
    logic         valid_q;
    logic         done_q;
    logic         err_q;

    logic         out_free_s;
    logic         at_last_s;
    logic         target_ok_s;

    // Fetch-decision helpers derived from the current registers and inputs.
    always_comb begin
        // The output register can take a new word when it is empty or is
        // being drained by decode this cycle.
        out_free_s  = (!valid_q) || ready_i;
        at_last_s   = (pc_q == LAST_PC);
        target_ok_s = (redirect_pc_i < INS_N);
    end

    // Fetch FSM: PC, output register, done and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= ZERO_PC;
            instr_q    <= ZERO_PC;
            instr_pc_q <= ZERO_PC;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Redirects are ignored here, so start always wins.
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (start_i) begin
                        state_q <= ST_RUN;
                        pc_q    <= ZERO_PC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_RUN, ST_HALT: begin
                    if (redirect_i) begin
                        // Drop the buffered word; a handshake happening on
                        // this edge has still been seen by decode.
                        valid_q <= 1'b0;
                        if (target_ok_s) begin
                            pc_q    <= redirect_pc_i;
                            state_q <= ST_RUN;
                            done_q  <= 1'b0;
                        end else begin
                            // Out-of-image target: stop, keep the PC.
                            state_q <= ST_HALT;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else if (state_q == ST_RUN) begin
                        done_q <= 1'b0;
                        if (out_free_s) begin
                            instr_q    <= imem_instr_i;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                            // The PC never wraps: the last word parks it.
                            if (at_last_s) begin
                                state_q <= ST_HALT;
                            end else begin
                                pc_q <= pc_q + ONE_PC;
                            end
                        end else begin
                            // Stalled: the PC and the output register hold,
                            // so the ROM is not re-sampled.
                            state_q <= ST_RUN;
                        end
                    end else begin
                        // Halted: only drain the final word.
                        if (valid_q && ready_i) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            done_q <= !valid_q;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_pc_o  = pc_q;
    assign instr_o    = instr_q;
    assign instr_pc_o = instr_pc_q;
    assign valid_o    = valid_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

    fetch_unit_checker #(
        .N   (N),
        .INS (INS)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .imem_pc_i  (pc_q),
        .instr_pc_i (instr_pc_q),
        .valid_i    (valid_q),
        .done_i     (done_q)
    );

endmodule

// ---------------------------------------------------------------------------
// fetch_unit_checker
//   Invariants of the fetch unit: the PC and the tag of a valid word stay
//   inside the image, and done is never raised while a word is pending.
//
// Ports (all inputs)
//   clk, rst     clock and active-high reset of the fetch unit
//   imem_pc_i    current PC
//   instr_pc_i   PC tag of the output register
//   valid_i      output register valid
//   done_i       done flag
// ---------------------------------------------------------------------------
module fetch_unit_checker #(
    parameter int N   = 32,
    parameter int INS = 10
) (
    input logic         clk,
    input logic         rst,
    input logic [N-1:0] imem_pc_i,
    input logic [N-1:0] instr_pc_i,
    input logic         valid_i,
    input logic         done_i
);

    localparam logic [N-1:0] INS_N = N'(INS);

    // Sample the invariants on every clock edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (imem_pc_i < INS_N)
                else $error("fetch_unit: PC outside image");
            assert (!valid_i || (instr_pc_i < INS_N))
                else $error("fetch_unit: valid word tagged outside image");
            assert (!(valid_i && done_i))
                else $error("fetch_unit: done with a pending word");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit (N=32, INS=10). A combinational ROM model
//   answers the fetch address; every check compares against hand-derived
//   PCs and the known ROM contents.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int N   = 32;
    localparam int INS = 10;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic [N-1:0] imem_pc_o;
    logic [N-1:0] imem_instr_i;
    logic [N-1:0] instr_o;
    logic [N-1:0] instr_pc_o;
    logic         valid_o;
    logic         ready_i;
    logic         redirect_i;
    logic [N-1:0] redirect_pc_i;
    logic         done_o;
    logic         err_o;

    int tests_run;
    int tests_failed;

    fetch_unit #(
        .N   (N),
        .INS (INS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .imem_pc_o     (imem_pc_o),
        .imem_instr_i  (imem_instr_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    // ROM image contents: a distinct word per address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'(INS)) begin
            rom_word = 32'hC0DE_0000 + (a * 32'h0000_0111);
        end else begin
            rom_word = 32'hDEAD_BEEF;
        end
    endfunction

    assign imem_instr_i = rom_word(imem_pc_o);

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        start_i       = 1'b0;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Pulse start; afterwards the unit is in RUN with nothing valid yet.
    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (valid_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 ||
            imem_pc_o !== 32'd0 || instr_o !== 32'd0 || instr_pc_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_values: valid=%b done=%b err=%b pc=%0d instr=%h ipc=%0d, required all 0",
                     valid_o, done_o, err_o, imem_pc_o, instr_o, instr_pc_o);
        end
        // IDLE without start: redirects (even out of range) are ignored.
        ready_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd12;
        step();
        redirect_pc_i = 32'd5;
        step();
        redirect_i = 1'b0;
        step();
        tests_run++;
        if (valid_o !== 1'b0 || imem_pc_o !== 32'd0 || err_o !== 1'b0 || done_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ignores_redirect: valid=%b pc=%0d err=%b done=%b, required 0/0/0/0",
                     valid_o, imem_pc_o, err_o, done_o);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        ready_i = 1'b1;
        pulse_start();
        tests_run++;
        if (valid_o !== 1'b0 || imem_pc_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL start_latency: valid=%b pc=%0d, required valid=0 pc=0", valid_o, imem_pc_o);
        end
        for (int i = 0; i < INS; i++) begin
            step();
            tests_run++;
            if (valid_o !== 1'b1 || instr_pc_o !== 32'(i) || instr_o !== rom_word(32'(i)) ||
                done_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL stream_word%0d: valid=%b ipc=%0d instr=%h done=%b, required 1/%0d/%h/0",
                         i, valid_o, instr_pc_o, instr_o, done_o, i, rom_word(32'(i)));
            end
        end
        step();
        tests_run++;
        if (valid_o !== 1'b0 || done_o !== 1'b1 || imem_pc_o !== 32'd9) begin
            tests_failed++;
            $display("FAIL stream_done: valid=%b done=%b pc=%0d, required 0/1/9", valid_o, done_o, imem_pc_o);
        end
        step();
        tests_run++;
        if (valid_o !== 1'b0 || done_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_stays: valid=%b done=%b, required 0/1", valid_o, done_o);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        ready_i = 1'b1;
        pulse_start();
        step();
        step();
        step();
        // Word 2 is now valid; decode stalls for three cycles.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (valid_o !== 1'b1 || instr_pc_o !== 32'd2 || instr_o !== rom_word(32'd2) ||
                imem_pc_o !== 32'd3) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: valid=%b ipc=%0d instr=%h pc=%0d, required 1/2/%h/3",
                         i, valid_o, instr_pc_o, instr_o, imem_pc_o, rom_word(32'd2));
            end
        end
        ready_i = 1'b1;
        for (int i = 3; i < INS; i++) begin
            step();
            tests_run++;
            if (valid_o !== 1'b1 || instr_pc_o !== 32'(i) || instr_o !== rom_word(32'(i))) begin
                tests_failed++;
                $display("FAIL stall_resume%0d: valid=%b ipc=%0d instr=%h, required 1/%0d/%h",
                         i, valid_o, instr_pc_o, instr_o, i, rom_word(32'(i)));
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        ready_i = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            step();
        end
        tests_run++;
        if (valid_o !== 1'b1 || instr_pc_o !== 32'd3) begin
            tests_failed++;
            $display("FAIL redirect_setup: valid=%b ipc=%0d, required 1/3", valid_o, instr_pc_o);
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd7;
        step();
        redirect_i = 1'b0;
        tests_run++;
        if (valid_o !== 1'b0 || imem_pc_o !== 32'd7 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_bubble: valid=%b pc=%0d err=%b, required 0/7/0", valid_o, imem_pc_o, err_o);
        end
        for (int i = 7; i < INS; i++) begin
            step();
            tests_run++;
            if (valid_o !== 1'b1 || instr_pc_o !== 32'(i) || instr_o !== rom_word(32'(i))) begin
                tests_failed++;
                $display("FAIL redirect_word%0d: valid=%b ipc=%0d instr=%h, required 1/%0d/%h",
                         i, valid_o, instr_pc_o, instr_o, i, rom_word(32'(i)));
            end
        end
        step();
        tests_run++;
        if (valid_o !== 1'b0 || done_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL redirect_done: valid=%b done=%b, required 0/1", valid_o, done_o);
        end
    endtask

    // Continues from the HALT left by test_redirect.
    task automatic test_halt_redirect();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd0;
        step();
        redirect_i = 1'b0;
        tests_run++;
        if (done_o !== 1'b0 || valid_o !== 1'b0 || imem_pc_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL halt_redirect_run: done=%b valid=%b pc=%0d, required 0/0/0", done_o, valid_o, imem_pc_o);
        end
        for (int i = 0; i < INS; i++) begin
            step();
            tests_run++;
            if (valid_o !== 1'b1 || instr_pc_o !== 32'(i) || instr_o !== rom_word(32'(i)) ||
                done_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL replay_word%0d: valid=%b ipc=%0d instr=%h done=%b, required 1/%0d/%h/0",
                         i, valid_o, instr_pc_o, instr_o, done_o, i, rom_word(32'(i)));
            end
        end
        step();
        tests_run++;
        if (valid_o !== 1'b0 || done_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL replay_done: valid=%b done=%b, required 0/1", valid_o, done_o);
        end
    endtask

    task automatic test_err();
        apply_reset();
        ready_i = 1'b1;
        pulse_start();
        step();
        step();
        // Word 1 valid, PC already at 2.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd12;
        step();
        redirect_i = 1'b0;
        tests_run++;
        if (err_o !== 1'b1 || valid_o !== 1'b0 || done_o !== 1'b1 || imem_pc_o !== 32'd2) begin
            tests_failed++;
            $display("FAIL err_redirect: err=%b valid=%b done=%b pc=%0d, required 1/0/1/2",
                     err_o, valid_o, done_o, imem_pc_o);
        end
        step();
        step();
        tests_run++;
        if (err_o !== 1'b1 || valid_o !== 1'b0 || imem_pc_o !== 32'd2) begin
            tests_failed++;
            $display("FAIL err_halt_nofetch: err=%b valid=%b pc=%0d, required 1/0/2", err_o, valid_o, imem_pc_o);
        end
        // Boundary: target INS is already out of range.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd10;
        step();
        redirect_pc_i = 32'd9;
        step();
        redirect_i = 1'b0;
        step();
        tests_run++;
        if (err_o !== 1'b1 || valid_o !== 1'b1 || instr_pc_o !== 32'd9 || instr_o !== rom_word(32'd9)) begin
            tests_failed++;
            $display("FAIL err_sticky_last: err=%b valid=%b ipc=%0d instr=%h, required 1/1/9/%h",
                     err_o, valid_o, instr_pc_o, instr_o, rom_word(32'd9));
        end
        apply_reset();
        tests_run++;
        if (err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_cleared: err=%b, required 0", err_o);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        ready_i       = 1'b1;
        start_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'd6;
        step();
        start_i    = 1'b0;
        redirect_i = 1'b0;
        step();
        tests_run++;
        if (valid_o !== 1'b1 || instr_pc_o !== 32'd0 || instr_o !== rom_word(32'd0) || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_beats_redirect: valid=%b ipc=%0d instr=%h err=%b, required 1/0/%h/0",
                     valid_o, instr_pc_o, instr_o, err_o, rom_word(32'd0));
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        ready_i = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            step();
        end
        // Word 3 valid: a start pulse now must be ignored.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        tests_run++;
        if (valid_o !== 1'b1 || instr_pc_o !== 32'd4) begin
            tests_failed++;
            $display("FAIL start_ignored_run: valid=%b ipc=%0d, required 1/4", valid_o, instr_pc_o);
        end
        step();
        tests_run++;
        if (valid_o !== 1'b1 || instr_pc_o !== 32'd5) begin
            tests_failed++;
            $display("FAIL midreset_setup: valid=%b ipc=%0d, required 1/5", valid_o, instr_pc_o);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (valid_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || imem_pc_o !== 32'd0 ||
            instr_o !== 32'd0 || instr_pc_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: valid=%b done=%b err=%b pc=%0d instr=%h ipc=%0d, required all 0",
                     valid_o, done_o, err_o, imem_pc_o, instr_o, instr_pc_o);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (valid_o !== 1'b0 || imem_pc_o !== 32'd0) begin
                tests_failed++;
                $display("FAIL midreset_idle%0d: valid=%b pc=%0d, required 0/0", i, valid_o, imem_pc_o);
            end
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        start_i       = 1'b0;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt_redirect();
        test_err();
        test_simultaneous();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
